issue_queue: RTL and testbench

//  Issue-queue storage and select stage, directly downstream of the free-slot finder. Dispatch/rename

---
 rtl/issue_queue_pkg.sv | 29 ++
 rtl/issue_picker.sv | 25 ++
 rtl/issue_queue.sv | 138 +++++++++++++
 tb/tb_issue_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_queue_pkg.sv
// Shared types for the issue queue: tag/ROB/payload widths, the queue entry
// record and the dispatch-time source-ready rule.
package issue_queue_pkg;

  localparam int unsigned PREG_W    = 6;
  localparam int unsigned ROB_W     = 5;
  localparam int unsigned PAYLOAD_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [PREG_W-1:0]    rs1;
    logic                 rs1_rdy;
    logic [PREG_W-1:0]    rs2;
    logic                 rs2_rdy;
    logic [PREG_W-1:0]    rd;
    logic [ROB_W-1:0]     rob;
    logic [PAYLOAD_W-1:0] payload;
  } iq_entry_t;

  // Source is ready at dispatch if rename says so, it is x0, or the CDB
  // is broadcasting it in the same cycle.
  function automatic logic src_ready(input logic [PREG_W-1:0] tag,
                                     input logic              rdy,
                                     input logic              cdb_valid,
                                     input logic [PREG_W-1:0] cdb_tag);
    return rdy | (tag == '0) | (cdb_valid & (cdb_tag == tag));
  endfunction

endpackage

// File: rtl/issue_picker.sv
// Lowest-index one-hot picker.
//   req     : request bits, one per queue entry
//   grant_c : one-hot grant of the lowest set request (zero if none)
//   any_c   : at least one request is set
module issue_picker #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant_c,
  output logic         any_c
);

  // First set bit wins; any_c doubles as the "already granted" flag.
  always_comb begin
    grant_c = '0;
    any_c   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !any_c) begin
        grant_c[i] = 1'b1;
        any_c      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Issue-queue storage and select stage.
//   clk, rst           : clock, synchronous active-high reset
//   flush              : drop all entries and the issue slot
//   disp_*             : one dispatch per cycle into alloc_addr (from free-slot finder)
//   queue_full         : dispatch ignored while high
//   cdb_valid, cdb_tag : wakeup broadcast
//   valid_vect         : registered occupancy vector for the finder
//   iss_* / iss_ready  : registered issue slot with valid/ready handshake
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter  int unsigned QUEUE_DEPTH = 3,
  localparam int unsigned IDX_W       = $clog2(QUEUE_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   disp_valid,
  input  logic [IDX_W-1:0]       alloc_addr,
  input  logic                   queue_full,
  input  logic [PREG_W-1:0]      disp_rs1,
  input  logic                   disp_rs1_rdy,
  input  logic [PREG_W-1:0]      disp_rs2,
  input  logic                   disp_rs2_rdy,
  input  logic [PREG_W-1:0]      disp_rd,
  input  logic [ROB_W-1:0]       disp_rob,
  input  logic [PAYLOAD_W-1:0]   disp_payload,
  input  logic                   cdb_valid,
  input  logic [PREG_W-1:0]      cdb_tag,
  output logic [QUEUE_DEPTH-1:0] valid_vect,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic [PREG_W-1:0]      iss_rs1,
  output logic [PREG_W-1:0]      iss_rs2,
  output logic [PREG_W-1:0]      iss_rd,
  output logic [ROB_W-1:0]       iss_rob,
  output logic [PAYLOAD_W-1:0]   iss_payload
);

  iq_entry_t              entries [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] entry_valid_c;
  logic [QUEUE_DEPTH-1:0] cand_c;
  logic [QUEUE_DEPTH-1:0] grant_c;
  logic [QUEUE_DEPTH-1:0] valid_next_c;
  logic                   any_cand_c;
  logic [IDX_W-1:0]       pick_idx_c;
  logic                   slot_free_c;
  logic                   addr_in_range_c;
  logic                   disp_req_c;
  logic                   disp_write_c;
  logic                   disp_illegal_c;
  iq_entry_t              disp_entry_c;

  // Candidates use registered ready bits only; no same-cycle wakeup bypass.
  always_comb begin
    entry_valid_c = '0;
    cand_c        = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      entry_valid_c[i] = entries[i].valid;
      cand_c[i]        = entries[i].valid & entries[i].rs1_rdy & entries[i].rs2_rdy;
    end
  end

  issue_picker #(.N(QUEUE_DEPTH)) u_picker (
    .req     (cand_c),
    .grant_c (grant_c),
    .any_c   (any_cand_c)
  );

  // One-hot grant to index for the issue-slot data mux.
  always_comb begin
    pick_idx_c = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (grant_c[i]) pick_idx_c = IDX_W'(i);
    end
  end

  assign slot_free_c     = !iss_valid || iss_ready;
  assign addr_in_range_c = 32'(alloc_addr) < QUEUE_DEPTH;
  assign disp_req_c      = disp_valid && !queue_full && addr_in_range_c;
  assign disp_write_c    = disp_req_c && !entry_valid_c[alloc_addr];
  assign disp_illegal_c  = disp_req_c && entry_valid_c[alloc_addr];

  // Dispatch record with the CDB bypass folded into the ready bits.
  always_comb begin
    disp_entry_c         = '0;
    disp_entry_c.valid   = 1'b1;
    disp_entry_c.rs1     = disp_rs1;
    disp_entry_c.rs1_rdy = src_ready(disp_rs1, disp_rs1_rdy, cdb_valid, cdb_tag);
    disp_entry_c.rs2     = disp_rs2;
    disp_entry_c.rs2_rdy = src_ready(disp_rs2, disp_rs2_rdy, cdb_valid, cdb_tag);
    disp_entry_c.rd      = disp_rd;
    disp_entry_c.rob     = disp_rob;
    disp_entry_c.payload = disp_payload;
  end

  // Entry occupancy after this edge: picked entry freed, dispatched entry set.
  always_comb begin
    valid_next_c = entry_valid_c;
    if (slot_free_c) valid_next_c = valid_next_c & ~grant_c;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (disp_write_c && (alloc_addr == IDX_W'(i))) valid_next_c[i] = 1'b1;
    end
  end

  // Entry array, issue slot and occupancy vector. valid_vect sets with the
  // dispatch but clears one cycle after the free, so the finder can never
  // re-hand out a slot in the cycle it is released.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) entries[i].valid <= 1'b0;
      valid_vect <= '0;
      iss_valid  <= 1'b0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (entries[i].valid && cdb_valid) begin
          if (entries[i].rs1 == cdb_tag) entries[i].rs1_rdy <= 1'b1;
          if (entries[i].rs2 == cdb_tag) entries[i].rs2_rdy <= 1'b1;
        end
        if (disp_write_c && (alloc_addr == IDX_W'(i))) entries[i] <= disp_entry_c;
        entries[i].valid <= valid_next_c[i];
      end
      if (slot_free_c) begin
        iss_valid   <= any_cand_c;
        iss_rs1     <= entries[pick_idx_c].rs1;
        iss_rs2     <= entries[pick_idx_c].rs2;
        iss_rd      <= entries[pick_idx_c].rd;
        iss_rob     <= entries[pick_idx_c].rob;
        iss_payload <= entries[pick_idx_c].payload;
      end
      valid_vect <= entry_valid_c | valid_next_c;
    end
  end

  // The finder must never allocate an occupied slot.
  a_no_overwrite : assert property (@(posedge clk) disable iff (rst) !disp_illegal_c);

endmodule

// File: tb/tb_issue_queue.sv
// Testbench for issue_queue: directed vector table, hand-written stall/full/flush
// sequences, then randomized traffic against a behavioural queue model.
module tb_issue_queue;

  logic        clk = 1'b0;
  logic        rst, flush, disp_valid, queue_full;
  logic [1:0]  alloc_addr;
  logic [5:0]  disp_rs1, disp_rs2, disp_rd, cdb_tag;
  logic        disp_rs1_rdy, disp_rs2_rdy, cdb_valid, iss_ready;
  logic [4:0]  disp_rob;
  logic [31:0] disp_payload;
  logic [2:0]  valid_vect;
  logic        iss_valid;
  logic [5:0]  iss_rs1, iss_rs2, iss_rd;
  logic [4:0]  iss_rob;
  logic [31:0] iss_payload;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid),
    .alloc_addr(alloc_addr), .queue_full(queue_full),
    .disp_rs1(disp_rs1), .disp_rs1_rdy(disp_rs1_rdy),
    .disp_rs2(disp_rs2), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rd(disp_rd), .disp_rob(disp_rob), .disp_payload(disp_payload),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .valid_vect(valid_vect),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_rob(iss_rob), .iss_payload(iss_payload)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; disp_valid = 0; queue_full = 0; alloc_addr = 0;
    disp_rs1 = 0; disp_rs1_rdy = 0; disp_rs2 = 0; disp_rs2_rdy = 0;
    disp_rd = 0; disp_rob = 0; disp_payload = 0; cdb_valid = 0; cdb_tag = 0;
  endtask

  task automatic disp(input int a, input int r1, input int r1r, input int r2,
                      input int r2r, input int rd);
    disp_valid = 1; alloc_addr = 2'(a);
    disp_rs1 = 6'(r1); disp_rs1_rdy = 1'(r1r);
    disp_rs2 = 6'(r2); disp_rs2_rdy = 1'(r2r);
    disp_rd = 6'(rd); disp_rob = 5'(rd); disp_payload = 32'(rd) + 32'h1000;
  endtask

  // Directed vectors: inputs for one cycle, outputs expected after that edge.
  typedef struct {
    int rst, flush, dv, addr, qf, rs1, r1r, rs2, r2r, cv, ct, ir;
    int e_iv, chk_d, e_rs1, e_rs2, e_vv;
  } vec_t;

  vec_t vecs[19];

  // Behavioural model: per-slot arrays plus one issue slot.
  bit          m_valid[3], m_r1r[3], m_r2r[3];
  logic [5:0]  m_r1[3], m_r2[3], m_rd[3];
  logic [4:0]  m_rob[3];
  logic [31:0] m_pay[3];
  bit          m_iv;
  logic [5:0]  m_srs1, m_srs2, m_srd;
  logic [4:0]  m_srob;
  logic [31:0] m_spay;
  logic [2:0]  m_vv;

  task automatic model_edge();
    bit nv[3];
    int pick;
    int a;
    if (rst || flush) begin
      for (int i = 0; i < 3; i++) m_valid[i] = 0;
      m_iv = 0;
      m_vv = 0;
      return;
    end
    pick = -1;
    for (int i = 0; i < 3; i++)
      if (m_valid[i] && m_r1r[i] && m_r2r[i]) begin pick = i; break; end
    nv = m_valid;
    for (int i = 0; i < 3; i++) begin
      if (m_valid[i] && cdb_valid && m_r1[i] == cdb_tag) m_r1r[i] = 1;
      if (m_valid[i] && cdb_valid && m_r2[i] == cdb_tag) m_r2r[i] = 1;
    end
    if (!m_iv || iss_ready) begin
      if (pick >= 0) begin
        m_iv = 1; m_srs1 = m_r1[pick]; m_srs2 = m_r2[pick]; m_srd = m_rd[pick];
        m_srob = m_rob[pick]; m_spay = m_pay[pick]; nv[pick] = 0;
      end else begin
        m_iv = 0;
      end
    end
    a = int'(alloc_addr);
    if (disp_valid && !queue_full && a < 3 && !m_valid[a]) begin
      nv[a] = 1;
      m_r1[a] = disp_rs1; m_r2[a] = disp_rs2; m_rd[a] = disp_rd;
      m_rob[a] = disp_rob; m_pay[a] = disp_payload;
      m_r1r[a] = disp_rs1_rdy || disp_rs1 == 0 || (cdb_valid && cdb_tag == disp_rs1);
      m_r2r[a] = disp_rs2_rdy || disp_rs2 == 0 || (cdb_valid && cdb_tag == disp_rs2);
    end
    for (int i = 0; i < 3; i++) m_vv[i] = m_valid[i] | nv[i];
    m_valid = nv;
  endtask

  initial begin
    idle();
    rst = 1; iss_ready = 1;

    vecs[0]  = '{1,0,0,0,0,  0,0, 0,0, 0, 0,1, 0,0, 0,0, 0};
    vecs[1]  = '{0,0,1,0,0,  5,1, 0,0, 0, 0,1, 0,0, 0,0, 1};
    vecs[2]  = '{0,0,0,0,0,  0,0, 0,0, 0, 0,1, 1,1, 5,0, 1};
    vecs[3]  = '{0,0,0,0,0,  0,0, 0,0, 0, 0,1, 0,0, 0,0, 0};
    vecs[4]  = '{0,0,1,1,0,  7,0, 0,0, 0, 0,1, 0,0, 0,0, 2};
    vecs[5]  = '{0,0,0,0,0,  0,0, 0,0, 0, 0,1, 0,0, 0,0, 2};
    vecs[6]  = '{0,0,0,0,0,  0,0, 0,0, 1, 7,1, 0,0, 0,0, 2};
    vecs[7]  = '{0,0,0,0,0,  0,0, 0,0, 0, 0,1, 1,1, 7,0, 2};
    vecs[8]  = '{0,0,0,0,0,  0,0, 0,0, 0, 0,1, 0,0, 0,0, 0};
    vecs[9]  = '{0,0,1,2,0,  0,0, 9,0, 1, 9,1, 0,0, 0,0, 4};
    vecs[10] = '{0,0,0,0,0,  0,0, 0,0, 0, 0,1, 1,1, 0,9, 4};
    vecs[11] = '{0,0,0,0,0,  0,0, 0,0, 0, 0,1, 0,0, 0,0, 0};
    vecs[12] = '{0,0,1,3,0,  5,1, 0,0, 0, 0,1, 0,0, 0,0, 0};
    vecs[13] = '{0,0,0,0,0,  0,0, 0,0, 0, 0,1, 0,0, 0,0, 0};
    vecs[14] = '{0,0,1,0,0, 12,0,12,0, 0, 0,1, 0,0, 0,0, 1};
    vecs[15] = '{0,0,0,0,0,  0,0, 0,0, 1,13,1, 0,0, 0,0, 1};
    vecs[16] = '{0,0,0,0,0,  0,0, 0,0, 1,12,1, 0,0, 0,0, 1};
    vecs[17] = '{0,0,0,0,0,  0,0, 0,0, 0, 0,1, 1,1,12,12,1};
    vecs[18] = '{0,0,0,0,0,  0,0, 0,0, 0, 0,1, 0,0, 0,0, 0};

    for (int n = 0; n < 19; n++) begin
      idle();
      rst = 1'(vecs[n].rst); flush = 1'(vecs[n].flush);
      if (vecs[n].dv != 0)
        disp(vecs[n].addr, vecs[n].rs1, vecs[n].r1r, vecs[n].rs2, vecs[n].r2r, 10);
      queue_full = 1'(vecs[n].qf);
      cdb_valid = 1'(vecs[n].cv); cdb_tag = 6'(vecs[n].ct);
      iss_ready = 1'(vecs[n].ir);
      tick();
      chk($sformatf("vec%0d iss_valid", n), 32'(iss_valid), 32'(vecs[n].e_iv));
      chk($sformatf("vec%0d valid_vect", n), 32'(valid_vect), 32'(vecs[n].e_vv));
      if (vecs[n].chk_d != 0) begin
        chk($sformatf("vec%0d iss_rs1", n), 32'(iss_rs1), 32'(vecs[n].e_rs1));
        chk($sformatf("vec%0d iss_rs2", n), 32'(iss_rs2), 32'(vecs[n].e_rs2));
      end
    end

    // Stalled issue slot with a filling queue, then drain in order.
    idle(); iss_ready = 0;
    disp(0, 1, 1, 0, 0, 20); tick();
    chk("stall vv0", 32'(valid_vect), 32'd1);
    chk("stall iv0", 32'(iss_valid), 32'd0);
    disp(1, 2, 1, 0, 0, 21); tick();
    chk("stall iv1", 32'(iss_valid), 32'd1);
    chk("stall rd1", 32'(iss_rd), 32'd20);
    chk("stall vv1", 32'(valid_vect), 32'd3);
    disp(2, 3, 1, 0, 0, 22); tick();
    chk("stall rd2", 32'(iss_rd), 32'd20);
    chk("stall vv2", 32'(valid_vect), 32'd6);
    idle();
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("hold iv", 32'(iss_valid), 32'd1);
      chk("hold rd", 32'(iss_rd), 32'd20);
      chk("hold rob", 32'(iss_rob), 32'd20);
      chk("hold vv", 32'(valid_vect), 32'd6);
    end
    iss_ready = 1; tick();
    chk("drain rd21", 32'(iss_rd), 32'd21);
    chk("drain iv21", 32'(iss_valid), 32'd1);
    chk("drain vv21", 32'(valid_vect), 32'd6);
    tick();
    chk("drain rd22", 32'(iss_rd), 32'd22);
    chk("drain pay22", iss_payload, 32'h1016);
    chk("drain vv22", 32'(valid_vect), 32'd4);
    tick();
    chk("drain empty iv", 32'(iss_valid), 32'd0);
    chk("drain empty vv", 32'(valid_vect), 32'd0);

    // Full queue ignores dispatch; wakeup still works; flush clears a held issue.
    idle(); iss_ready = 0;
    disp(0, 30, 0, 0, 0, 30); tick();
    disp(1, 31, 0, 0, 0, 31); tick();
    disp(2, 32, 0, 0, 0, 32); tick();
    idle();
    chk("full vv", 32'(valid_vect), 32'd7);
    disp(0, 1, 1, 0, 0, 40); queue_full = 1; tick();
    chk("full drop vv", 32'(valid_vect), 32'd7);
    idle(); queue_full = 1; tick();
    chk("full drop iv", 32'(iss_valid), 32'd0);
    cdb_valid = 1; cdb_tag = 31; tick();
    cdb_valid = 0;
    chk("full wake early", 32'(iss_valid), 32'd0);
    tick();
    chk("full wake iv", 32'(iss_valid), 32'd1);
    chk("full wake rd", 32'(iss_rd), 32'd31);
    chk("full wake vv", 32'(valid_vect), 32'd7);
    tick();
    chk("full held rd", 32'(iss_rd), 32'd31);
    chk("full held vv", 32'(valid_vect), 32'd5);
    flush = 1; tick();
    idle();
    chk("flush iv", 32'(iss_valid), 32'd0);
    chk("flush vv", 32'(valid_vect), 32'd0);
    cdb_valid = 1; cdb_tag = 30; tick();
    cdb_valid = 0; tick();
    chk("post flush iv", 32'(iss_valid), 32'd0);
    chk("post flush vv", 32'(valid_vect), 32'd0);

    // Randomized traffic against the model.
    idle(); rst = 1; iss_ready = 1;
    model_edge(); tick();
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 149) == 0);
      queue_full = &m_vv;
      if ($urandom_range(0, 2) != 0) begin
        int a;
        a = 3;
        if (queue_full) a = int'($urandom_range(0, 3));
        else if ($urandom_range(0, 15) != 0)
          for (int i = 2; i >= 0; i--) if (!m_vv[i]) a = i;
        disp(a, int'($urandom_range(0, 7)), int'($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 63)));
        disp_rob = 5'($urandom);
        disp_payload = $urandom;
      end
      cdb_valid = 1'($urandom_range(0, 1));
      cdb_tag   = 6'($urandom_range(0, 7));
      iss_ready = ($urandom_range(0, 2) != 0);
      model_edge();
      tick();
      chk("rand iss_valid", 32'(iss_valid), 32'(m_iv));
      chk("rand valid_vect", 32'(valid_vect), 32'(m_vv));
      if (m_iv) begin
        chk("rand iss_rs1", 32'(iss_rs1), 32'(m_srs1));
        chk("rand iss_rs2", 32'(iss_rs2), 32'(m_srs2));
        chk("rand iss_rd", 32'(iss_rd), 32'(m_srd));
        chk("rand iss_rob", 32'(iss_rob), 32'(m_srob));
        chk("rand iss_payload", iss_payload, m_spay);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
